// File: rtl/alu_sequencer.sv
// alu_sequencer: runs a short program from a local instruction buffer through an
// external combinational processing unit, chaining each result into the accumulator.
module alu_sequencer #(
    parameter int LENGTH = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [7:0]        wr_opcode_i,
    input  logic [LENGTH-1:0] wr_imm_i,
    input  logic [AW:0]       prog_len_i,
    input  logic [LENGTH-1:0] init_acc_i,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [LENGTH-1:0] acc_o,
    output logic              ovf_sticky_o,
    output logic [AW:0]       pc_o,
    output logic [7:0]        pu_opcode_o,
    output logic [LENGTH-1:0] pu_a_o,
    output logic [LENGTH-1:0] pu_b_o,
    input  logic [LENGTH-1:0] pu_out_i,
    input  logic              pu_ovf_i
);

    localparam logic [7:0] OP_HALT      = 8'hFF;
    localparam logic [7:0] OP_PASS      = 8'h0A;
    localparam logic [7:0] OP_NOFLAG_HI = 8'h0F;
    localparam logic [AW:0] DEPTH_LEN   = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        ISSUE   = 3'd2,
        CAPTURE = 3'd3,
        FIN     = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [LENGTH-1:0]   acc_q, acc_d;
    logic [AW:0]         pc_q, pc_d;
    logic [AW:0]         len_q, len_d;
    logic                ovf_q, ovf_d;
    logic [7:0]          pu_op_q, pu_op_d;
    logic [LENGTH-1:0]   pu_b_q, pu_b_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [7:0]          op_mem  [DEPTH];
    logic [LENGTH-1:0]   imm_mem [DEPTH];
    logic [7:0]          cur_op_s;
    logic [LENGTH-1:0]   cur_imm_s;
    logic [AW:0]         pc_next_s;
    logic                flag_stale_s;

    assign cur_op_s     = op_mem[pc_q[AW-1:0]];
    assign cur_imm_s    = imm_mem[pc_q[AW-1:0]];
    assign pc_next_s    = pc_q + (AW+1)'(1);
    // Logic, shift and pass ops leave the unit's overflow flag meaningless.
    assign flag_stale_s = (pu_op_q >= OP_PASS) && (pu_op_q <= OP_NOFLAG_HI);

    // Instruction buffer: no reset, writes locked out while a program runs.
    always_ff @(posedge clk_i) begin
        if (wr_en_i && !busy_q) begin
            op_mem[wr_addr_i]  <= wr_opcode_i;
            imm_mem[wr_addr_i] <= wr_imm_i;
        end
    end

    // Next-state and datapath register updates; abort wins over everything.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        pc_d    = pc_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        pu_op_d = pu_op_q;
        pu_b_d  = pu_b_q;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        state_d = LOAD;
                        acc_d   = init_acc_i;
                        pc_d    = '0;
                        ovf_d   = 1'b0;
                        len_d   = (prog_len_i > DEPTH_LEN) ? DEPTH_LEN : prog_len_i;
                    end else begin
                        state_d = IDLE;
                    end
                end
                LOAD: begin
                    if (len_q != '0) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = FIN;
                    end
                end
                ISSUE: begin
                    if (cur_op_s == OP_HALT) begin
                        state_d = FIN;
                    end else begin
                        state_d = CAPTURE;
                        pu_op_d = cur_op_s;
                        pu_b_d  = cur_imm_s;
                    end
                end
                CAPTURE: begin
                    acc_d = pu_out_i;
                    pc_d  = pc_next_s;
                    if (flag_stale_s) begin
                        ovf_d = ovf_q;
                    end else begin
                        ovf_d = ovf_q | pu_ovf_i;
                    end
                    if (pc_next_s < len_q) begin
                        state_d = ISSUE;
                    end else begin
                        state_d = FIN;
                    end
                end
                FIN:     state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == LOAD) || (state_d == ISSUE) || (state_d == CAPTURE);
        done_d = (state_d == FIN);
    end

    // State and output registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            pc_q    <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            pu_op_q <= OP_PASS;
            pu_b_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            pu_op_q <= pu_op_d;
            pu_b_q  <= pu_b_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign acc_o        = acc_q;
    assign ovf_sticky_o = ovf_q;
    assign pc_o         = pc_q;
    assign pu_opcode_o  = pu_op_q;
    assign pu_a_o       = acc_q;
    assign pu_b_o       = pu_b_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: table of programs with a result scoreboard, plus
// hand-written abort, write-lockout, clamp and asynchronous-reset sequences.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_addr = 4'd0;
    logic [7:0]  wr_opcode = 8'd0;
    logic [15:0] wr_imm = 16'd0;
    logic [4:0]  prog_len = 5'd0;
    logic [15:0] init_acc = 16'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        busy, done, ovf_sticky;
    logic [15:0] acc, pu_a, pu_b, pu_out;
    logic [4:0]  pc;
    logic [7:0]  pu_opcode;
    logic        pu_ovf;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0][7:0]  op;    // op[0] is instruction 0
        logic [3:0][15:0] imm;
        logic [4:0]       len;
        logic [15:0]      init;
        logic [15:0]      exp_acc;
        logic             exp_ovf;
        logic [4:0]       exp_pc;
        logic [7:0]       exp_lat;
    } vec_t;

    typedef struct packed {
        logic [15:0] acc;
        logic        ovf;
        logic [4:0]  pc;
        logic [7:0]  lat;
    } exp_t;

    vec_t vecs[8];
    exp_t sb[$];

    alu_sequencer #(.LENGTH(16), .DEPTH(16), .AW(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
        .wr_opcode_i(wr_opcode), .wr_imm_i(wr_imm), .prog_len_i(prog_len),
        .init_acc_i(init_acc), .start_i(start), .abort_i(abort), .busy_o(busy),
        .done_o(done), .acc_o(acc), .ovf_sticky_o(ovf_sticky), .pc_o(pc),
        .pu_opcode_o(pu_opcode), .pu_a_o(pu_a), .pu_b_o(pu_b),
        .pu_out_i(pu_out), .pu_ovf_i(pu_ovf)
    );

    always #5 clk = ~clk;

    // Processing-unit model; logic/shift/pass ops drive a deliberately bogus ovf=1.
    logic [16:0] sum17, dif17;
    always_comb begin
        sum17  = {pu_a[15], pu_a} + {pu_b[15], pu_b};
        dif17  = {pu_a[15], pu_a} - {pu_b[15], pu_b};
        pu_out = sum17[15:0];
        pu_ovf = sum17[16] ^ sum17[15];
        case (pu_opcode)
            8'h08: begin
                pu_ovf = sum17[16] ^ sum17[15];
                pu_out = pu_ovf ? (sum17[16] ? 16'h8000 : 16'h7FFF) : sum17[15:0];
            end
            8'h09: begin
                pu_ovf = dif17[16] ^ dif17[15];
                pu_out = pu_ovf ? (dif17[16] ? 16'h8000 : 16'h7FFF) : dif17[15:0];
            end
            8'h0a: begin pu_out = pu_b;                          pu_ovf = 1'b1; end
            8'h0b: begin pu_out = pu_a & pu_b;                   pu_ovf = 1'b1; end
            8'h0c: begin pu_out = pu_a | pu_b;                   pu_ovf = 1'b1; end
            8'h0d: begin pu_out = $signed(pu_a) >>> pu_b[3:0];   pu_ovf = 1'b1; end
            8'h0e: begin pu_out = pu_a << pu_b[3:0];             pu_ovf = 1'b1; end
            8'h0f: begin pu_out = pu_a ^ pu_b;                   pu_ovf = 1'b1; end
            default: begin
                pu_out = sum17[15:0];
                pu_ovf = sum17[16] ^ sum17[15];
            end
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic write_instr(input logic [3:0] a, input logic [7:0] op, input logic [15:0] imm);
        wr_en = 1'b1; wr_addr = a; wr_opcode = op; wr_imm = imm;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic start_run(input logic [4:0] len, input logic [15:0] init, input string tag);
        prog_len = len; init_acc = init; start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, " busy_in_load"}, 32'(busy), 32'd1);
    endtask

    // Pops the next expected result and waits (bounded) for done.
    task automatic wait_done(input string tag);
        exp_t e;
        int   lat;
        bit   seen;
        e = sb.pop_front();
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 100) begin
            tick();
            lat++;
            if (done) seen = 1'b1;
        end
        check({tag, " done_latency"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(e.lat));
        check({tag, " acc"}, 32'(acc), 32'(e.acc));
        check({tag, " pu_a"}, 32'(pu_a), 32'(e.acc));
        check({tag, " ovf_sticky"}, 32'(ovf_sticky), 32'(e.ovf));
        check({tag, " pc"}, 32'(pc), 32'(e.pc));
        check({tag, " busy_in_fin"}, 32'(busy), 32'd0);
        tick();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
    endtask

    function automatic vec_t mk(input logic [31:0] ops, input logic [63:0] imms,
                                input logic [4:0] len, input logic [15:0] init,
                                input logic [15:0] ea, input logic eo,
                                input logic [4:0] epc, input logic [7:0] lat);
        vec_t v;
        v.op = ops; v.imm = imms; v.len = len; v.init = init;
        v.exp_acc = ea; v.exp_ovf = eo; v.exp_pc = epc; v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_cnt;
        // Latency counts edges after the start edge: 2N+1 for a full run, 2k+2 for HALT at k.
        vecs[0] = mk(32'h00_0e_09_08, 64'h0000_0003_0002_0005, 5'd3, 16'h0001, 16'h0020, 1'b0, 5'd3, 8'd7);
        vecs[1] = mk(32'h00_00_0b_08, 64'h0000_0000_00FF_7FFF, 5'd2, 16'h0001, 16'h00FF, 1'b1, 5'd2, 8'd5);
        vecs[2] = mk(32'h00_08_ff_0a, 64'h0000_0001_0000_0007, 5'd3, 16'h0100, 16'h0007, 1'b0, 5'd1, 8'd4);
        vecs[3] = mk(32'h00_00_00_08, 64'h0000_0000_0000_0001, 5'd0, 16'h1234, 16'h1234, 1'b0, 5'd0, 8'd1);
        vecs[4] = mk(32'h0a_0d_0f_0c, 64'h8000_0004_00FF_F0F0, 5'd4, 16'h0F00, 16'h8000, 1'b0, 5'd4, 8'd9);
        vecs[5] = mk(32'h00_00_10_09, 64'h0000_0000_0003_0002, 5'd2, 16'h8001, 16'h8003, 1'b1, 5'd2, 8'd5);
        vecs[6] = mk(32'h00_00_00_20, 64'h0000_0000_0000_7FFF, 5'd1, 16'h0001, 16'h8000, 1'b1, 5'd1, 8'd3);
        vecs[7] = mk(32'h00_00_08_ff, 64'h0000_0000_0005_0000, 5'd2, 16'h0042, 16'h0042, 1'b0, 5'd0, 8'd2);

        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset acc", 32'(acc), 32'd0);
        check("reset ovf", 32'(ovf_sticky), 32'd0);
        check("reset pc", 32'(pc), 32'd0);
        check("reset pu_opcode", 32'(pu_opcode), 32'h0a);
        check("reset pu_b", 32'(pu_b), 32'd0);
        check("reset pu_out", 32'(pu_out), 32'd0);
        rst_n = 1'b1;
        tick();

        for (int v = 0; v < 8; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            for (int i = 0; i < 4; i++) write_instr(4'(i), vecs[v].op[i], vecs[v].imm[i]);
            sb.push_back({vecs[v].exp_acc, vecs[v].exp_ovf, vecs[v].exp_pc, vecs[v].exp_lat});
            start_run(vecs[v].len, vecs[v].init, tag);
            wait_done(tag);
        end

        // prog_len beyond the buffer runs every entry once.
        for (int i = 0; i < 16; i++) write_instr(4'(i), 8'h08, 16'h0001);
        sb.push_back({16'd16, 1'b0, 5'd16, 8'd33});
        start_run(5'd31, 16'h0000, "clamp");
        wait_done("clamp");

        // Abort in the second CAPTURE keeps the first result and suppresses done.
        write_instr(4'd0, 8'h08, 16'h000A);
        write_instr(4'd1, 8'h08, 16'h0014);
        write_instr(4'd2, 8'h08, 16'h001E);
        write_instr(4'd3, 8'h08, 16'h0028);
        start_run(5'd4, 16'h0000, "abort");
        tick(); tick(); tick(); tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", 32'(busy), 32'd0);
        check("abort acc", 32'(acc), 32'h000A);
        check("abort pc", 32'(pc), 32'd1);
        done_cnt = 32'(done);
        for (int i = 0; i < 6; i++) begin
            tick();
            done_cnt += 32'(done);
        end
        check("abort no_done", 32'(done_cnt), 32'd0);
        check("abort stays_idle", 32'(busy), 32'd0);

        // A write while busy must not reach the buffer.
        write_instr(4'd0, 8'h0a, 16'h0005);
        sb.push_back({16'h0005, 1'b0, 5'd1, 8'd2});
        start_run(5'd1, 16'h0000, "lockout");
        wr_en = 1'b1; wr_addr = 4'd0; wr_opcode = 8'h0a; wr_imm = 16'h0063;
        tick();
        wr_en = 1'b0;
        wait_done("lockout");
        sb.push_back({16'h0005, 1'b0, 5'd1, 8'd3});
        start_run(5'd1, 16'h0000, "lockout_rerun");
        wait_done("lockout_rerun");

        // Same-cycle write and start: the new instruction executes.
        wr_en = 1'b1; wr_addr = 4'd0; wr_opcode = 8'h0a; wr_imm = 16'h0ABC;
        sb.push_back({16'h0ABC, 1'b0, 5'd1, 8'd3});
        start_run(5'd1, 16'h0000, "wr_start");
        wr_en = 1'b0;
        wait_done("wr_start");

        // Asynchronous reset in the middle of a CAPTURE cycle.
        write_instr(4'd0, 8'h08, 16'h0010);
        write_instr(4'd1, 8'h08, 16'h0020);
        start_run(5'd2, 16'h0050, "areset");
        tick(); tick();
        check("areset pre_pu_b", 32'(pu_b), 32'h0010);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset busy", 32'(busy), 32'd0);
        check("areset done", 32'(done), 32'd0);
        check("areset acc", 32'(acc), 32'd0);
        check("areset ovf", 32'(ovf_sticky), 32'd0);
        check("areset pc", 32'(pc), 32'd0);
        check("areset pu_opcode", 32'(pu_opcode), 32'h0a);
        check("areset pu_b", 32'(pu_b), 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            done_cnt += 32'(done);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            done_cnt += 32'(done);
        end
        check("areset no_done", 32'(done_cnt), 32'd0);
        check("areset idle_after", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
